// File: rtl/rf_wb_arbiter_if.sv
// Writeback-lanes / register-file bus bundle for rf_wb_arbiter.
// Forwarding lookup signals exist only when RF_WB_FWD_EN is defined.
interface rf_wb_arbiter_if #(
  parameter int unsigned RS    = 5,
  parameter int unsigned RD    = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          wb0_valid;
  logic [RS-1:0] wb0_rd;
  logic [RD-1:0] wb0_data;
  logic          wb0_ready;
  logic          wb1_valid;
  logic [RS-1:0] wb1_rd;
  logic [RD-1:0] wb1_data;
  logic          wb1_ready;
  logic          rf_write_en;
  logic [RS-1:0] rf_rd;
  logic [RD-1:0] rf_wd;
  logic [CW-1:0] count;
  logic          busy;
`ifdef RF_WB_FWD_EN
  logic [RS-1:0] fwd_rs;
  logic          fwd_hit;
  logic [RD-1:0] fwd_data;
`endif

  modport master (
    output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    input  wb0_ready, wb1_ready, rf_write_en, rf_rd, rf_wd, count, busy
`ifdef RF_WB_FWD_EN
    , output fwd_rs, input fwd_hit, fwd_data
`endif
  );

  modport slave (
    input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    output wb0_ready, wb1_ready, rf_write_en, rf_rd, rf_wd, count, busy
`ifdef RF_WB_FWD_EN
    , input fwd_rs, output fwd_hit, fwd_data
`endif
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Merges two writeback lanes into one RF write port via an order-preserving queue.
// Define RF_WB_FWD_EN to add a combinational youngest-match forwarding lookup.
module rf_wb_arbiter #(
  parameter int unsigned RS    = 5,
  parameter int unsigned RD    = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [RS-1:0] r_q_rd [DEPTH];
  logic [RD-1:0] r_q_wd [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_rf_we;
  logic [RS-1:0] r_rf_rd;
  logic [RD-1:0] r_rf_wd;

  logic          w_rdy0;
  logic          w_rdy1;
  logic          w_enq0;
  logic          w_enq1;
  logic          w_pop;
  logic [PW-1:0] w_tail1;
  logic [CW-1:0] w_nenq;

  assign w_rdy0  = (r_count <= CW'(DEPTH - 1));
  assign w_rdy1  = (r_count <= CW'(DEPTH - 2));
  // rd==0 completes the handshake but is never stored
  assign w_enq0  = bus.wb0_valid && w_rdy0 && (bus.wb0_rd != '0);
  assign w_enq1  = bus.wb1_valid && w_rdy1 && (bus.wb1_rd != '0);
  assign w_pop   = (r_count != '0);
  assign w_tail1 = w_enq0 ? r_tail + PW'(1) : r_tail;
  assign w_nenq  = CW'(w_enq0) + CW'(w_enq1);

  always_ff @(posedge clk) begin
    if (w_enq0) begin
      r_q_rd[r_tail] <= bus.wb0_rd;
      r_q_wd[r_tail] <= bus.wb0_data;
    end
    if (w_enq1) begin
      r_q_rd[w_tail1] <= bus.wb1_rd;
      r_q_wd[w_tail1] <= bus.wb1_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_rf_we <= 1'b0;
      r_rf_rd <= '0;
      r_rf_wd <= '0;
    end else begin
      r_tail  <= r_tail + PW'(w_nenq);
      r_count <= r_count + w_nenq - CW'(w_pop);
      r_rf_we <= w_pop;
      if (w_pop) begin
        r_rf_rd <= r_q_rd[r_head];
        r_rf_wd <= r_q_wd[r_head];
        r_head  <= r_head + PW'(1);
      end
    end
  end

  assign bus.wb0_ready   = w_rdy0;
  assign bus.wb1_ready   = w_rdy1;
  assign bus.rf_write_en = r_rf_we;
  assign bus.rf_rd       = r_rf_rd;
  assign bus.rf_wd       = r_rf_wd;
  assign bus.count       = r_count;
  assign bus.busy        = w_pop || r_rf_we;

`ifdef RF_WB_FWD_EN
  logic          w_fwd_hit;
  logic [RD-1:0] w_fwd_data;

  // Output register first, then queue oldest-to-newest, so the youngest match wins
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    if (bus.fwd_rs != '0) begin
      if (r_rf_we && (r_rf_rd == bus.fwd_rs)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_rf_wd;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < r_count) && (r_q_rd[r_head + PW'(i)] == bus.fwd_rs)) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = r_q_wd[r_head + PW'(i)];
        end
      end
    end
  end

  assign bus.fwd_hit  = w_fwd_hit;
  assign bus.fwd_data = w_fwd_data;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: driver pushes expected RF writes, a negedge monitor checks them.
// Forwarding checks compile in when RF_WB_FWD_EN is defined.
module tb_rf_wb_arbiter;
  localparam int unsigned RS    = 5;
  localparam int unsigned RD    = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [RS-1:0] rd;
    logic [RD-1:0] wd;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.RS(RS), .RD(RD), .DEPTH(DEPTH)) bus ();
  rf_wb_arbiter #(.RS(RS), .RD(RD), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t sb[$];
  wr_t mq[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  m_cnt = 0;
  bit  m_we  = 1'b0;
  wr_t m_last = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.rf_write_en === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_write: got rd=%0d wd=0x%0h expected no write at %0t",
                   bus.rf_rd, bus.rf_wd, $time);
        end else begin
          e = sb.pop_front();
          chk("rf_rd", 64'(bus.rf_rd), 64'(e.rd));
          chk("rf_wd", 64'(bus.rf_wd), 64'(e.wd));
        end
      end
    end
  end

  // Called just after a negedge; checks state, drives one cycle, returns model acceptance.
  task automatic cycle(input bit v0, input logic [RS-1:0] rd0, input logic [RD-1:0] d0,
                       input bit v1, input logic [RS-1:0] rd1, input logic [RD-1:0] d1,
                       output bit a0, output bit a1);
    bit  r0, r1, pop;
    int  enq;
    wr_t e;
    r0 = (m_cnt <= int'(DEPTH) - 1);
    r1 = (m_cnt <= int'(DEPTH) - 2);
    chk("count", 64'(bus.count), 64'(m_cnt));
    chk("wb0_ready", 64'(bus.wb0_ready), 64'(r0));
    chk("wb1_ready", 64'(bus.wb1_ready), 64'(r1));
    chk("rf_write_en", 64'(bus.rf_write_en), 64'(m_we));
    chk("busy", 64'(bus.busy), 64'((m_cnt != 0) || m_we));
    if (!m_we) begin
      chk("rf_rd_hold", 64'(bus.rf_rd), 64'(m_last.rd));
      chk("rf_wd_hold", 64'(bus.rf_wd), 64'(m_last.wd));
    end
    bus.wb0_valid = v0; bus.wb0_rd = rd0; bus.wb0_data = d0;
    bus.wb1_valid = v1; bus.wb1_rd = rd1; bus.wb1_data = d1;
    a0  = v0 && r0;
    a1  = v1 && r1;
    pop = (m_cnt > 0);
    enq = 0;
    if (a0 && rd0 != '0) begin
      e.rd = rd0; e.wd = d0; sb.push_back(e); mq.push_back(e); enq++;
    end
    if (a1 && rd1 != '0) begin
      e.rd = rd1; e.wd = d1; sb.push_back(e); mq.push_back(e); enq++;
    end
    @(posedge clk);
    m_we = pop;
    if (pop) m_last = mq.pop_front();
    m_cnt = m_cnt + enq - (pop ? 1 : 0);
    @(negedge clk);
    bus.wb0_valid = 1'b0;
    bus.wb1_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a0, a1;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, a0, a1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : driver
    bit            a0, a1, p0, p1;
    logic [RS-1:0] rd_a, rd_b;
    logic [RD-1:0] d_a, d_b;
    int unsigned   nxt;
    bus.wb0_valid = 1'b0; bus.wb0_rd = '0; bus.wb0_data = '0;
    bus.wb1_valid = 1'b0; bus.wb1_rd = '0; bus.wb1_data = '0;
`ifdef RF_WB_FWD_EN
    bus.fwd_rs = '0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_we", 64'(bus.rf_write_en), 64'd0);
    chk("reset_count", 64'(bus.count), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    rst = 1'b1;
    idle(2);

    // single push, lane 0
    cycle(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, '0, '0, a0, a1);
    idle(3);

    // dual push, same rd: RF must see 1 then 2
    cycle(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, a0, a1);
    idle(4);

    // rd==0 on lane 0 is accepted but dropped
    cycle(1'b1, 5'd0, 32'h0000_FFFF, 1'b1, 5'd3, 32'h33, a0, a1);
    chk("rd0_acc0", 64'(a0), 64'd1);
    idle(3);

    // continuous dual pushes; unaccepted requests are held
    p0 = 1'b0; p1 = 1'b0; nxt = 1;
    for (int i = 0; i < 10; i++) begin
      if (!p0) begin p0 = 1'b1; rd_a = RS'(nxt % 31 + 1); d_a = 32'h100 + nxt; nxt++; end
      if (!p1) begin p1 = 1'b1; rd_b = RS'(nxt % 31 + 1); d_b = 32'h100 + nxt; nxt++; end
      cycle(p0, rd_a, d_a, p1, rd_b, d_b, a0, a1);
      if (a0) p0 = 1'b0;
      if (a1) p1 = 1'b0;
    end
    while (p0 || p1) begin
      cycle(p0, rd_a, d_a, p1, rd_b, d_b, a0, a1);
      if (a0) p0 = 1'b0;
      if (a1) p1 = 1'b0;
    end
    idle(6);

`ifdef RF_WB_FWD_EN
    cycle(1'b1, 5'd9, 32'd4, 1'b1, 5'd9, 32'd8, a0, a1);
    bus.fwd_rs = 5'd9;
    #1;
    chk("fwd_hit_x9", 64'(bus.fwd_hit), 64'd1);
    chk("fwd_data_x9", 64'(bus.fwd_data), 64'd8);
    bus.fwd_rs = 5'd10;
    #1;
    chk("fwd_miss_hit", 64'(bus.fwd_hit), 64'd0);
    chk("fwd_miss_data", 64'(bus.fwd_data), 64'd0);
    bus.fwd_rs = 5'd0;
    #1;
    chk("fwd_x0_hit", 64'(bus.fwd_hit), 64'd0);
    idle(1);
    bus.fwd_rs = 5'd9;
    #1;
    chk("fwd_x9_late", 64'(bus.fwd_data), 64'd8);
    bus.fwd_rs = 5'd0;
    idle(4);
`endif

    // build count=3 then reset asynchronously between edges
    cycle(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC, a0, a1);
    cycle(1'b1, 5'd13, 32'hD, 1'b1, 5'd14, 32'hE, a0, a1);
    chk("pre_reset_count", 64'(bus.count), 64'd3);
    #2 rst = 1'b0;
    #1;
    chk("mid_reset_we", 64'(bus.rf_write_en), 64'd0);
    chk("mid_reset_rd", 64'(bus.rf_rd), 64'd0);
    chk("mid_reset_wd", 64'(bus.rf_wd), 64'd0);
    chk("mid_reset_count", 64'(bus.count), 64'd0);
    chk("mid_reset_busy", 64'(bus.busy), 64'd0);
    sb.delete();
    mq.delete();
    m_cnt = 0; m_we = 1'b0; m_last = '0;
    @(negedge clk);
    rst = 1'b1;
    idle(6);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Merges the two superscalar writeback lanes onto the single register-file write port.
- Order-preserving queue: lane 0 is older than lane 1 in the same cycle.
- Drains at most one write per cycle into the RF.
- Sits between the writeback stage and the register file. Applies backpressure to the lanes when full.

Parameters:
- RS, 5, register index width.
- RD, 32, data width.
- DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- wb0_valid  in  1  lane 0 (older) write request.
- wb0_rd  in  RS  lane 0 destination index.
- wb0_data  in  RD  lane 0 write data.
- wb0_ready  out  1  lane 0 may push this cycle.
- wb1_valid  in  1  lane 1 (younger) write request.
- wb1_rd  in  RS  lane 1 destination index.
- wb1_data  in  RD  lane 1 write data.
- wb1_ready  out  1  lane 1 may push this cycle.
- rf_write_en  out  1  to RF write_en.
- rf_rd  out  RS  to RF rd.
- rf_wd  out  RD  to RF wd.
- count  out  $clog2(DEPTH)+1  queue occupancy, excluding the output register.
- busy  out  1  queue non-empty or rf_write_en set.

Behaviour:
- Reset (rst low, async): pointers and count are 0. rf_write_en, rf_rd and rf_wd are 0. busy is 0. Ready outputs follow from count=0, so both are 1 once rst is released. Queue contents are don't-care.
- Reset asserted mid-operation discards all queued and in-flight writes; nothing reaches the RF afterwards.
- Ready outputs are combinational from the registered count only, never from valid:
  - wb0_ready = (count <= DEPTH-1)
  - wb1_ready = (count <= DEPTH-2)
- Push rule: a lane pushes on a posedge when valid && ready.
- rd==0 requests are accepted (handshake completes) but not enqueued.
- Simultaneous pushes: lane 0 goes into the tail entry, lane 1 into tail+1. Tail advances by the number of enqueued entries (0, 1 or 2).
- Pop rule: on each posedge where count>0 (value before the edge), the head entry is loaded into rf_rd/rf_wd, rf_write_en is set to 1, and head advances by 1.
  - If count==0, rf_write_en is set to 0; rf_rd/rf_wd hold their values.
  - Entries pushed at an edge cannot pop at the same edge (no bypass).
- Latency: a push at edge N appears on rf_* from edge N+1 at the earliest. The RF captures it on the falling edge within that cycle. Queued writes drain at one per cycle in strict program order, so same-rd writes resolve to the youngest.
- Count: count_next = count + pushes_enqueued - pop. Push and pop at the same edge are legal at any occupancy the ready rules permit.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Full boundaries:
  - count==DEPTH: both readies are 0.
  - count==DEPTH-1: only lane 0 is ready.
- Valid while not ready: the request is not consumed and the lane must hold it.
- rf_wd/rf_rd never change while rf_write_en==0 except at reset.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- When defined, adds ports fwd_rs (in, RS), fwd_hit (out, 1) and fwd_data (out, RD).
  - Combinational lookup of fwd_rs against the valid queue entries and the output register when rf_write_en==1.
  - Returns the youngest match: newest queue entry first, then older entries, then the output register.
  - fwd_rs==0 never hits. On a miss, fwd_hit=0 and fwd_data=0.
  - Lets the read stage see writes not yet committed to the RF.
- When undefined: none of these ports or logic exist, and behaviour is otherwise identical.

Test Plan:
- Reset then idle: rf_write_en=0, count=0, wb0_ready=wb1_ready=1, busy=0.
- One push, lane 0 writes x5=0xA5A5A5A5 at edge N: at edge N+1, rf_write_en=1, rf_rd=5, rf_wd=0xA5A5A5A5. At edge N+2, rf_write_en=0 and count=0.
- Dual push, lane 0 x7=1 and lane 1 x7=2 in the same cycle: the RF sees x7=1 then x7=2 on consecutive cycles, with final reg x7=2.
- Fill with DEPTH=4: dual pushes every cycle. Once count=3, wb1_ready=0 and wb0_ready=1. Once count=4, both are 0. No entry is lost or duplicated (scoreboard compare of drained sequence).
- rd==0 handling: lane 0 x0=0xFFFF and lane 1 x3=0x33 together. Only x3 is enqueued, count increments by 1, and the RF never sees rd=0.
- Reset mid-operation: count=3, assert rst low asynchronously between edges. Outputs are 0 immediately, and after release no stale write appears. With RF_WB_FWD_EN, queue x9=4 then x9=8, set fwd_rs=9: fwd_hit=1 and fwd_data=8.
